mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles a memory access may wait for mem_rdy before abort.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 if_req  input  1  instruction-fetch request; held high until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address, valid while if_req high.
REQ-008 if_rdata  output  DATA_W  fetched word, registered.
REQ-009 if_ack  output  1  one-cycle completion pulse for fetch.
REQ-010 d_req  input  1  data-access request; held high until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load; valid with d_req.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_rdata  output  DATA_W  load result, registered.
REQ-015 d_ack  output  1  one-cycle completion pulse for data access.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid when mem_rdy high.
REQ-021 mem_rdy  input  1  memory completion, may arrive any cycle mem_en is high.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 The FSM SHALL have states IDLE, SERVE_I, SERVE_D.
REQ-024 In IDLE, a requester whose ack is high in the current cycle SHALL be ignored.
REQ-025 In IDLE with only one eligible request, that requester SHALL be granted; with both, the one not granted last SHALL win (round-robin; last-grant register resets to data, so fetch wins first tie).
REQ-026 On grant, the arbiter SHALL latch address, we (0 for fetch) and wdata into registers and enter SERVE_I/SERVE_D next edge.
REQ-027 In SERVE_x, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL drive the latched values, stable for the whole state; in IDLE mem_en, mem_we SHALL be 0.
REQ-028 In SERVE_x with mem_rdy=1, the arbiter SHALL return to IDLE, pulse the matching ack for exactly the next cycle, and for loads/fetches capture mem_rdata into if_rdata/d_rdata at that edge.
REQ-029 Stores SHALL NOT modify d_rdata.
REQ-030 Minimum latency: request sampled at edge N, ack high in cycle after edge N+2 (mem_rdy in first SERVE cycle); no back-to-back grant to the same requester without an intervening IDLE cycle.
REQ-031 A wait counter SHALL clear on entering SERVE_x and increment each SERVE cycle with mem_rdy=0; on reaching TIMEOUT the arbiter SHALL abort: return to IDLE, pulse ack, load rdata with 0 (loads/fetches), set err.
REQ-032 err SHALL remain 1 until reset; it SHALL NOT block further arbitration.
REQ-033 mem_rdy in IDLE SHALL be ignored.
REQ-034 Request deassertion during SERVE_x SHALL NOT abort the access.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, all outputs 0 (acks, rdata, mem_*, err), wait counter 0, last-grant = data, regardless of an access in progress.
REQ-036 After rst rises, the first arbitration SHALL occur at the next rising clk edge.

Verification
REQ-037 Fetch alone: if_req, if_addr=0x40, mem_rdy one cycle after mem_en, mem_rdata=0x1234ABCD -> mem_addr=0x40, mem_we=0, if_ack one cycle, if_rdata=0x1234ABCD.
REQ-038 Simultaneous if_req and d_req (load 0x80) from reset -> fetch served first, then load; third tie -> fetch again (alternation verified over 4 ties).
REQ-039 Store d_addr=0x10, d_wdata=0xDEADBEEF, mem_rdy after 3 wait cycles -> mem_we=1 with stable addr/data 4 cycles, d_ack one pulse, d_rdata unchanged.
REQ-040 mem_rdy never asserted -> abort after TIMEOUT=15 wait cycles, ack pulse, rdata=0, err=1 and stays 1 through subsequent good accesses.
REQ-041 rst=0 mid SERVE_D -> outputs 0 asynchronously before next edge, err cleared; after release a pending if_req is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets an instruction-fetch port and a data port share one memory port.
// Each access waits for mem_rdy, or is aborted after TIMEOUT wait cycles with rdata forced to 0 and err latched.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              state, state_nxt;
  logic                last_d, last_d_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                we_q, we_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt, rd_val;
  logic                if_ack_nxt, d_ack_nxt, err_nxt;
  logic                i_ok, d_ok, pick_d, timeout_hit, done;

  always_comb begin
    // A requester still seeing its ack this cycle is finishing, not asking again.
    i_ok        = if_req && !if_ack;
    d_ok        = d_req && !d_ack;
    pick_d      = d_ok && (!i_ok || !last_d);
    timeout_hit = !mem_rdy && (wait_cnt == CNT_W'(TIMEOUT - 1));
    done        = mem_rdy || timeout_hit;
    rd_val      = mem_rdy ? mem_rdata : '0;

    state_nxt    = state;
    last_d_nxt   = last_d;
    addr_nxt     = addr_q;
    we_nxt       = we_q;
    wdata_nxt    = wdata_q;
    wait_cnt_nxt = wait_cnt;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    if_ack_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;
    err_nxt      = err;

    case (state)
      IDLE: begin
        if (i_ok || d_ok) begin
          wait_cnt_nxt = '0;
          last_d_nxt   = pick_d;
          if (pick_d) begin
            state_nxt = SERVE_D;
            addr_nxt  = d_addr;
            we_nxt    = d_we;
            wdata_nxt = d_wdata;
          end else begin
            state_nxt = SERVE_I;
            addr_nxt  = if_addr;
            we_nxt    = 1'b0;
            wdata_nxt = '0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (done) begin
          state_nxt = IDLE;
          if (!mem_rdy) err_nxt = 1'b1;
          if (state == SERVE_I) begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = rd_val;
          end else begin
            d_ack_nxt = 1'b1;
            if (!we_q) d_rdata_nxt = rd_val;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      addr_q   <= addr_nxt;
      we_q     <= we_nxt;
      wdata_q  <= wdata_nxt;
      wait_cnt <= wait_cnt_nxt;
      if_rdata <= if_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
      if_ack   <= if_ack_nxt;
      d_ack    <= d_ack_nxt;
      err      <= err_nxt;
    end
  end

  assign mem_en    = (state != IDLE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests against a transaction-level model of the memory port.
// The model is fed the service order each test expects and is checked against the DUT every cycle.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, err;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;

  int          total = 0, bad = 0;
  int          cyc = 0, ack_cyc = 0;
  int          rdy_delay = 0;
  logic [31:0] rd_val = '0;
  int          ia_cnt = 0, da_cnt = 0, en_cnt = 0, we_cnt = 0;

  typedef struct packed {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t expq[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic d, input logic we, input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.d = d; t.we = we; t.addr = a; t.wdata = w;
    expq.push_back(t);
  endtask

  // Memory responder: mem_rdy comes rdy_delay wait cycles into each access.
  int rcnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (!rst || !mem_en) begin
      rcnt    = 0;
      mem_rdy = 1'b0;
    end else begin
      mem_rdy = (rcnt == rdy_delay);
      rcnt++;
    end
    mem_rdata = mem_rdy ? rd_val : $urandom();
  end

  always @(negedge clk) begin
    if (rst) begin
      if (if_ack) ia_cnt++;
      if (d_ack) da_cnt++;
      if (mem_en) en_cnt++;
      if (mem_en && mem_we) we_cnt++;
    end
  end

  // Transaction-level model of the memory port and completion side.
  txn_t        cur;
  bit          busy = 0, just_done = 0;
  int          wcyc = 0;
  bit          p_i = 0, p_d = 0, p_err = 0, p_upd_i = 0, p_upd_d = 0;
  logic [31:0] p_val = '0, e_if_rd = '0, e_d_rd = '0;
  bit          e_err = 0, e_if_ack, e_d_ack;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_mem_en_we", 64'({mem_en, mem_we}), 64'(0));
      chk("rst_acks_err", 64'({if_ack, d_ack, err}), 64'(0));
      chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
      chk("rst_mem_addr_wdata", 64'({mem_addr, mem_wdata}), 64'(0));
      busy = 0; just_done = 0; p_i = 0; p_d = 0; p_err = 0; p_upd_i = 0; p_upd_d = 0;
      e_if_rd = '0; e_d_rd = '0; e_err = 0;
      expq.delete();
    end else begin
      e_if_ack = p_i;
      e_d_ack  = p_d;
      if (p_upd_i) e_if_rd = p_val;
      if (p_upd_d) e_d_rd = p_val;
      if (p_err) e_err = 1;
      p_i = 0; p_d = 0; p_upd_i = 0; p_upd_d = 0; p_err = 0;
      chk("if_ack", 64'(if_ack), 64'(e_if_ack));
      chk("d_ack", 64'(d_ack), 64'(e_d_ack));
      chk("if_rdata", 64'(if_rdata), 64'(e_if_rd));
      chk("d_rdata", 64'(d_rdata), 64'(e_d_rd));
      chk("err", 64'(err), 64'(e_err));
      if (just_done) begin
        chk("idle_gap_mem_en", 64'({mem_en, mem_we}), 64'(0));
        just_done = 0;
      end else begin
        if (mem_en && !busy) begin
          chk("grant_expected", 64'(expq.size() > 0), 64'(1));
          if (expq.size() > 0) begin
            cur  = expq.pop_front();
            busy = 1;
            wcyc = 0;
          end
        end else begin
          chk("mem_en", 64'({mem_en, mem_we && !busy}), 64'({busy, 1'b0}));
        end
        if (busy && mem_en) begin
          chk("mem_we", 64'(mem_we), 64'(cur.we));
          chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
          if (cur.we) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
          if (!mem_rdy) wcyc++;
          if (mem_rdy || wcyc == TIMEOUT) begin
            p_i = !cur.d;
            p_d = cur.d;
            p_err = !mem_rdy;
            if (!cur.we) begin
              p_val   = mem_rdy ? mem_rdata : 32'h0;
              p_upd_i = !cur.d;
              p_upd_d = cur.d;
            end
            busy = 0;
            just_done = 1;
          end
        end
      end
    end
  end

  // Waits for the needed acks, dropping each request once its ack has been seen.
  // seq starts at 1 and shifts in 0 for a fetch ack, 1 for a data ack.
  task automatic run(input bit need_i, input bit need_d, input int budget, output int seq);
    bit gi, gd;
    seq = 1;
    gi = !need_i;
    gd = !need_d;
    for (int c = 0; c < budget && !(gi && gd); c++) begin
      @(negedge clk);
      if (if_ack) begin seq = seq * 2; gi = 1; ack_cyc = cyc; end
      if (d_ack) begin seq = seq * 2 + 1; gd = 1; ack_cyc = cyc; end
      @(posedge clk);
      #1;
      if (gi) if_req = 1'b0;
      if (gd) d_req = 1'b0;
    end
    chk("acks_within_budget", 64'({gi, gd}), 64'(2'b11));
  endtask

  task automatic tie(input bit d_first, input logic [31:0] rv, output int seq);
    rd_val = rv;
    if (d_first) begin
      push(1, 0, 32'h80, 32'h0);
      push(0, 0, 32'h44, 32'h0);
    end else begin
      push(0, 0, 32'h44, 32'h0);
      push(1, 0, 32'h80, 32'h0);
    end
    if_addr = 32'h44; d_addr = 32'h80; d_we = 1'b0; d_wdata = 32'h0;
    if_req = 1'b1; d_req = 1'b1;
    run(1, 1, 60, seq);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int seq, c0, n0, n1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({mem_en, if_ack, d_ack, err}), 64'(0));
    rst = 1'b1;
    rdy_delay = 0;

    // Ties: fresh ties keep going to fetch because data was granted last.
    tie(0, 32'hA5A50001, seq); chk("tie1_order", 64'(seq), 64'(5));
    chk("tie1_rdata", 64'({if_rdata, d_rdata}), {32'hA5A50001, 32'hA5A50001});
    tie(0, 32'hA5A50002, seq); chk("tie2_order", 64'(seq), 64'(5));
    tie(0, 32'hA5A50003, seq); chk("tie3_order", 64'(seq), 64'(5));
    push(0, 0, 32'h44, 32'h0);
    if_addr = 32'h44; if_req = 1'b1;
    run(1, 0, 30, seq); chk("single_fetch_order", 64'(seq), 64'(2));
    tie(1, 32'hA5A50004, seq); chk("tie4_order", 64'(seq), 64'(6));
    chk("tie4_d_rdata", 64'(d_rdata), 64'(32'hA5A50004));

    // Fetch alone with one wait cycle.
    rdy_delay = 1; rd_val = 32'h1234ABCD;
    push(0, 0, 32'h40, 32'h0);
    if_addr = 32'h40; if_req = 1'b1; c0 = cyc; n0 = ia_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("fetch_grant_mem", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, 32'h40}));
    run(1, 0, 30, seq);
    chk("fetch_ack_latency", 64'(ack_cyc - c0), 64'(3));
    repeat (2) @(posedge clk);
    chk("fetch_ack_pulses", 64'(ia_cnt - n0), 64'(1));
    chk("fetch_rdata", 64'(if_rdata), 64'(32'h1234ABCD));

    // Store with three wait cycles leaves d_rdata alone.
    #1;
    rdy_delay = 3; rd_val = 32'hFFFF0000;
    push(1, 1, 32'h10, 32'hDEADBEEF);
    d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    n0 = we_cnt; n1 = da_cnt;
    run(0, 1, 30, seq);
    repeat (2) @(posedge clk);
    chk("store_we_cycles", 64'(we_cnt - n0), 64'(4));
    chk("store_ack_pulses", 64'(da_cnt - n1), 64'(1));
    chk("store_d_rdata_kept", 64'(d_rdata), 64'(32'hA5A50004));

    // Memory never answers: abort after TIMEOUT wait cycles, err sticks.
    #1;
    rdy_delay = 1000;
    push(0, 0, 32'h48, 32'h0);
    if_addr = 32'h48; if_req = 1'b1; n0 = en_cnt;
    run(1, 0, 40, seq);
    chk("timeout_serve_cycles", 64'(en_cnt - n0), 64'(15));
    chk("timeout_rdata_err", 64'({if_rdata, err}), 64'({32'h0, 1'b1}));
    rdy_delay = 0; rd_val = 32'h0BADF00D;
    push(1, 0, 32'h84, 32'h0);
    d_we = 1'b0; d_addr = 32'h84; d_req = 1'b1;
    run(0, 1, 30, seq);
    chk("err_sticky_after_good", 64'({err, d_rdata}), 64'({1'b1, 32'h0BADF00D}));

    // Reset in the middle of a data access, with a fetch pending.
    rdy_delay = 1000;
    push(1, 1, 32'h20, 32'h0055AA00);
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0055AA00; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if_addr = 32'h4C; if_req = 1'b1;
    @(posedge clk);
    #3;
    chk("pre_reset_serving", 64'({mem_en, mem_we}), 64'(2'b11));
    rst = 1'b0;
    #1;
    chk("async_rst_mem", 64'({mem_en, mem_we, mem_addr}), 64'(0));
    chk("async_rst_flags", 64'({if_ack, d_ack, err, mem_wdata}), 64'(0));
    chk("async_rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rdy_delay = 0; rd_val = 32'h600DCAFE;
    push(0, 0, 32'h4C, 32'h0);
    push(1, 1, 32'h20, 32'h0055AA00);
    rst = 1'b1;
    run(1, 1, 40, seq);
    chk("post_reset_order", 64'(seq), 64'(5));
    chk("post_reset_state", 64'({err, if_rdata}), 64'({1'b0, 32'h600DCAFE}));

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(expq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
